display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
//
// PURPOSE
//   Time-multiplexes a 4-digit BCD value onto the seven_seg decoder.
//   - Drives the decoder's en[1:0] digit select and num[3:0] code.
//   - Double-buffers display updates so a new value only appears at a frame boundary (no tearing).
//   - Optionally shows a minus sign and blanks leading zeros.
//   - Sits between the multiplier result/BCD logic and seven_seg.
//
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles each digit stays lit; legal range >=2; counter width derived internally
//
// PORTS
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   digits       in   16  BCD value; [15:12]=thousands (leftmost) .. [3:0]=units
//   neg          in   1   1 = show minus sign in leftmost position
//   blank_lz     in   1   1 = blank leading zeros
//   load         in   1   1-cycle strobe: capture digits/neg/blank_lz into pending buffer
//   upd_pending  out  1   pending buffer holds a value not yet displayed
//   en           out  2   digit select to seven_seg; 0 = leftmost .. 3 = rightmost
//   num          out  4   code to seven_seg; 0-9 digit, 10 = minus, 11 = blank
//   frame_done   out  1   1-cycle pulse when the scan wraps from position 3 to 0
//
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - prescaler=0, idx=0, en=0, num=11, frame_done=0, upd_pending=0.
//   - Active and pending buffers cleared: digits=0, neg=0, blank_lz=0.
//   Prescaler and scan:
//   - Prescaler counts 0..REFRESH_DIV-1. tick=1 when count==REFRESH_DIV-1; count then returns to 0.
//   - On a tick edge: idx<=idx+1 (mod 4), en<=new idx, num<=code(new idx). en and num update on the same edge.
//   - After reset, first tick occurs at cycle REFRESH_DIV.
//   - Full frame = 4*REFRESH_DIV cycles.
//   Update handshake:
//   - load=1 copies inputs into pending and sets upd_pending=1.
//   - A load while already pending overwrites it; last load wins.
//   - Commit happens on the tick edge where idx wraps 3->0. If upd_pending, active<=pending and upd_pending<=0.
//   - frame_done=1 for that single cycle, whether or not a commit happened.
//   - Position-0 code on the wrap edge is computed from the newly committed buffer.
//   - load in the same cycle as a commit: the commit uses the pre-existing pending value.
//     The new value becomes pending (upd_pending stays 1) and is shown at the next frame.
//   Code generation, position p, from the active buffer:
//   - p=0 and neg=1: code 10 (minus).
//   - blank_lz=1: a position whose nibble is 0 and all positions to its left (excluding a minus)
//     are 0/blank gets code 11. Position 3 is never blanked.
//   - Otherwise code = nibble. Nibbles 10-15 pass through unmodified; no range checking.
//   - The minus replaces the thousands digit; the upstream source keeps magnitude <=999 when neg=1.
//   Reset mid-frame: all state returns to reset values immediately, and any pending value is lost.
//
// TESTING (bench uses REFRESH_DIV=4)
//   1. Reset, no load -> en=0,num=11 until cycle 4. Then en cycles 1,2,3,0 every 4 clks, num=0 each
//      (blank_lz=0). frame_done pulses at cycle 16.
//   2. load digits=16'h1234,neg=0,blank_lz=0 mid-frame -> upd_pending=1 until next wrap edge.
//      Then num sequence 1,2,3,4 with en 0..3, and upd_pending=0.
//   3. digits=16'h0045, blank_lz=1, neg=0 -> num 11,11,4,5.
//      digits=16'h0000 -> num 11,11,11,0.
//   4. digits=16'h0007, neg=1, blank_lz=1 -> num 10,11,11,7.
//      Same with blank_lz=0 -> num 10,0,0,7.
//   5. Two loads in one frame (16'h1111 then 16'h2222), then load 16'h3333 exactly on the wrap edge
//      -> frame shows 2,2,2,2; upd_pending stays 1; following frame shows 3,3,3,3.
//   6. Assert rst_n=0 asynchronously mid-digit with upd_pending=1
//      -> en=0,num=11,upd_pending=0 without waiting for clk; old pending value never displayed.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit scan controller for the seven_seg decoder.
// Frame-synchronous double buffer, minus sign, leading-zero blanking.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        neg,
  input  logic        blank_lz,
  input  logic        load,
  output logic        upd_pending,
  output logic [1:0]  en,
  output logic [3:0]  num,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    en_q, en_d;
  logic [3:0]    num_q, num_d;
  logic          fd_q, fd_d;
  logic          upd_q, upd_d;
  logic [15:0]   act_dig_q, act_dig_d;
  logic          act_neg_q, act_neg_d;
  logic          act_blz_q, act_blz_d;
  logic [15:0]   pnd_dig_q, pnd_dig_d;
  logic          pnd_neg_q, pnd_neg_d;
  logic          pnd_blz_q, pnd_blz_d;
  logic          tick, wrap;

  // lz tracks whether every digit left of the current one is zero,
  // skipping position 0 when it carries the minus sign.
  function automatic logic [3:0] code_of(
    input logic [15:0] d,
    input logic        n,
    input logic        b,
    input logic [1:0]  p
  );
    logic       lz;
    logic [3:0] nb;
    logic [3:0] res;
    lz  = 1'b1;
    res = 4'd0;
    for (int i = 0; i < 4; i++) begin
      nb = d[(3-i)*4 +: 4];
      if (2'(i) == p) begin
        if (i == 0 && n)
          res = 4'd10;
        else if (b && i != 3 && nb == 4'd0 && lz)
          res = 4'd11;
        else
          res = nb;
      end
      if (!(i == 0 && n) && nb != 4'd0)
        lz = 1'b0;
    end
    return res;
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    en_d      = en_q;
    num_d     = num_q;
    upd_d     = upd_q;
    act_dig_d = act_dig_q;
    act_neg_d = act_neg_q;
    act_blz_d = act_blz_q;
    pnd_dig_d = pnd_dig_q;
    pnd_neg_d = pnd_neg_q;
    pnd_blz_d = pnd_blz_q;

    tick = (cnt_q == LAST);
    wrap = tick && (idx_q == 2'd3);
    fd_d = wrap;

    cnt_d = tick ? '0 : cnt_q + CW'(1);

    if (wrap && upd_q) begin
      act_dig_d = pnd_dig_q;
      act_neg_d = pnd_neg_q;
      act_blz_d = pnd_blz_q;
      upd_d     = 1'b0;
    end

    // A load on the commit edge becomes the next pending value.
    if (load) begin
      pnd_dig_d = digits;
      pnd_neg_d = neg;
      pnd_blz_d = blank_lz;
      upd_d     = 1'b1;
    end

    if (tick) begin
      idx_d = idx_q + 2'd1;
      en_d  = idx_d;
      num_d = code_of(act_dig_d, act_neg_d, act_blz_d, idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      en_q      <= 2'd0;
      num_q     <= 4'd11;
      fd_q      <= 1'b0;
      upd_q     <= 1'b0;
      act_dig_q <= 16'h0;
      act_neg_q <= 1'b0;
      act_blz_q <= 1'b0;
      pnd_dig_q <= 16'h0;
      pnd_neg_q <= 1'b0;
      pnd_blz_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      num_q     <= num_d;
      fd_q      <= fd_d;
      upd_q     <= upd_d;
      act_dig_q <= act_dig_d;
      act_neg_q <= act_neg_d;
      act_blz_q <= act_blz_d;
      pnd_dig_q <= pnd_dig_d;
      pnd_neg_q <= pnd_neg_d;
      pnd_blz_q <= pnd_blz_d;
    end
  end

  assign upd_pending = upd_q;
  assign en          = en_q;
  assign num         = num_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: edge-count reference model plus
// directed frame checks and randomized loads.
module tb_display_scan_ctrl;

  localparam int DIV = 4;
  localparam int FRM = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0;
  logic        neg = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic        upd_pending;
  logic [1:0]  en;
  logic [3:0]  num;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits(digits),
    .neg(neg),
    .blank_lz(blank_lz),
    .load(load),
    .upd_pending(upd_pending),
    .en(en),
    .num(num),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: n = clock edges since reset release
  int          m_n;
  logic [15:0] m_ad, m_pd;
  logic        m_an, m_ab, m_pn, m_pb, m_up;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0;
      m_ad = 0; m_an = 0; m_ab = 0;
      m_pd = 0; m_pn = 0; m_pb = 0;
      m_up = 0;
    end else begin
      m_n = m_n + 1;
      if (m_n % FRM == 0 && m_up) begin
        m_ad = m_pd; m_an = m_pn; m_ab = m_pb;
        m_up = 0;
      end
      if (load) begin
        m_pd = digits; m_pn = neg; m_pb = blank_lz;
        m_up = 1;
      end
    end
  end

  function automatic int nib(input logic [15:0] d, input int p);
    return int'((d >> (4 * (3 - p))) & 16'hF);
  endfunction

  function automatic int ref_code(input logic [15:0] d, input logic n,
                                  input logic b, input int p);
    int start, fnz;
    start = n ? 1 : 0;
    fnz = 3;
    for (int i = 3; i >= start; i--)
      if (nib(d, i) != 0) fnz = i;
    if (p == 0 && n) return 10;
    if (b && p < 3 && p < fnz) return 11;
    return nib(d, p);
  endfunction

  function automatic int exp_en();
    return (m_n / DIV) % 4;
  endfunction

  function automatic int exp_num();
    if (m_n < DIV) return 11;
    return ref_code(m_ad, m_an, m_ab, exp_en());
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  bit run_cmp = 0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("en", int'(en), exp_en());
      chk("num", int'(num), exp_num());
      chk("frame_done", int'(frame_done),
          (m_n > 0 && m_n % FRM == 0) ? 1 : 0);
      chk("upd_pending", int'(upd_pending), int'(m_up));
    end
  end

  task automatic wait_until(input int ph);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_n % FRM != ph && k < 64);
    if (m_n % FRM != ph) chk("wait_timeout", m_n % FRM, ph);
  endtask

  task automatic do_load(input logic [15:0] d, input logic n,
                         input logic b);
    digits = d; neg = n; blank_lz = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic show_frame(input int e0, e1, e2, e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int p = 0; p < 4; p++) begin
      chk("frame_en", int'(en), p);
      chk("frame_num", int'(num), e[p]);
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic check_frame(input int e0, e1, e2, e3);
    wait_until(0);
    show_frame(e0, e1, e2, e3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_num", int'(num), 11);
    chk("rst_upd", int'(upd_pending), 0);
    rst_n = 1'b1;
    run_cmp = 1;

    // 1: idle scan after reset
    for (int i = 0; i < DIV; i++) begin
      chk("t1_en0", int'(en), 0);
      chk("t1_num11", int'(num), 11);
      @(negedge clk);
    end
    chk("t1_en1", int'(en), 1);
    wait_until(0);
    chk("t1_fd", int'(frame_done), 1);
    show_frame(0, 0, 0, 0);

    // 2: mid-frame load shown at next frame
    wait_until(6);
    do_load(16'h1234, 1'b0, 1'b0);
    chk("t2_pend", int'(upd_pending), 1);
    check_frame(1, 2, 3, 4);
    chk("t2_pend_clr", int'(upd_pending), 0);

    // 3/4: blanking and minus
    do_load(16'h0045, 1'b0, 1'b1);
    check_frame(11, 11, 4, 5);
    do_load(16'h0000, 1'b0, 1'b1);
    check_frame(11, 11, 11, 0);
    do_load(16'h0007, 1'b1, 1'b1);
    check_frame(10, 11, 11, 7);
    do_load(16'h0007, 1'b1, 1'b0);
    check_frame(10, 0, 0, 7);

    // 5: last load wins; load on the wrap edge waits a frame
    wait_until(2);
    do_load(16'h1111, 1'b0, 1'b0);
    wait_until(8);
    do_load(16'h2222, 1'b0, 1'b0);
    wait_until(15);
    do_load(16'h3333, 1'b0, 1'b0);
    chk("t5_pend", int'(upd_pending), 1);
    show_frame(2, 2, 2, 2);
    chk("t5_fd", int'(frame_done), 1);
    show_frame(3, 3, 3, 3);
    chk("t5_pend_clr", int'(upd_pending), 0);

    // randomized loads against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits = 16'($urandom);
        neg = 1'($urandom);
        blank_lz = 1'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;

    // 6: async reset mid-digit drops the pending value
    wait_until(5);
    do_load(16'h9876, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_en", int'(en), 0);
    chk("t6_num", int'(num), 11);
    chk("t6_upd", int'(upd_pending), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(0, 0, 0, 0);
    chk("t6_upd_after", int'(upd_pending), 0);

    run_cmp = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
